fides_inv_mcol_serial: RTL
==========================

Name: fides_inv_mcol_serial

Overview:
Column-serial inverse MixColumns engine for the FIDES-192 threshold-implementation decryption datapath. It accepts a 3-share 192-bit state (4 rows x 8 columns of 6-bit cells) and processes one column per cycle. Each share is transformed independently, since the transform is linear. The result is returned through a valid/ready handshake, and the block sits between the inverse ShiftRows and inverse S-box stages of the decryption round.

Parameters:
CELL_W, 6, cell width in bits
NROW, 4, cells per column
NCOL, 8, columns per state
NSHARE, 3, number of TI shares

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  input state valid
in_ready  out  1  engine can accept a state
in_s0  in  192  input share 0
in_s1  in  192  input share 1
in_s2  in  192  input share 2
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_s0  out  192  output share 0
out_s1  out  192  output share 1
out_s2  out  192  output share 2
busy  out  1  high in RUN or DONE

Behaviour:
- The design has one clock. Reset is synchronous and active-high.
- State bit map: cell (r,c) occupies bits [CELL_W*(NROW*c+r) +: CELL_W]; row 0 is least significant within a column. Column c is bits [24c +: 24].
- Column transform, per share: y_r = XOR of the three other cells in the column (y0=a1^a2^a3, y1=a0^a2^a3, y2=a0^a1^a3, y3=a0^a1^a2). The matrix is involutory, so this transform is also the inverse MixColumns. There is no cross-share mixing.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid, all three shares load into state registers, col_cnt=0, and the FSM goes to RUN.
- RUN: in_ready=0. Each cycle, column col_cnt of every share is replaced by its transform. col_cnt increments; at col_cnt=NCOL-1 the counter wraps to 0 and the FSM goes to DONE.
- DONE: out_valid=1. out_s* are driven directly from the state registers and held stable until out_ready. When out_valid&&out_ready, the FSM goes to IDLE.
- Latency: input handshake in cycle T, columns 0..7 processed in T+1..T+8, out_valid first high in T+9.
- Throughput: 1 state per 10 cycles minimum. There is a one-cycle bubble in IDLE; in_ready is not asserted in DONE.
- in_valid while not in IDLE is ignored; in_ready is low then. A source holding in_valid is served once the FSM returns to IDLE.
- out_ready high while out_valid is low has no effect.
- Reset values: state registers 0, col_cnt 0, FSM IDLE, in_ready 1 in the cycle after reset, out_valid 0, busy 0, out_s* 0.
- Reset mid-RUN or mid-DONE discards the in-flight state. There is no partial output.
- out_s* equals the state registers at all times. Data is only meaningful while out_valid=1.

Optional Feature:
- Macro: FIDES_INV_MCOL_UNROLL_EN.
- Defined: all NCOL column transforms are applied in a single RUN cycle. RUN lasts exactly 1 cycle, col_cnt is unused and held at 0, and out_valid first goes high in T+2.
- Undefined: serial behaviour as specified above. The handshake and reset behaviour are identical in both builds.

Decomposition:
- Shared package fides_pkg: CELL_W, NROW, NCOL, NSHARE, STATE_W=192; typedefs cell_t [5:0], col_t [23:0], state_t [191:0]; FSM state enum.
- One sub-module, fides_inv_mcol_col: combinational 4-cell column transform. It is instantiated NSHARE times in the serial build and NSHARE*NCOL times in the unrolled build.

Test Plan:
- Single column: share0 column0 = cells (01,00,00,00), all else 0 -> out share0 column0 = (00,01,01,01); all other cells 0; out_valid at T+9.
- All cells 3F in all shares -> every output cell 3F. All cells 2A -> every output cell 2A.
- Involution: random state X passed through twice -> second result equals X bit-exactly for all three shares.
- Share correctness: random shares; out_s0^out_s1^out_s2 equals the column transform of in_s0^in_s1^in_s2; each share matches the per-share reference model.
- Backpressure: out_ready held low for 5 cycles in DONE -> out_valid and out_s* stable. in_valid asserted meanwhile is not accepted; it is accepted the cycle after the output handshake.
- Reset at T+4 mid-RUN -> next cycle FSM in IDLE, out_valid=0, out_s*=0, in_ready=1. A new state is then processed correctly with no residue from the aborted one.

Source files
------------

// File: rtl/fides_pkg.sv
// rtl/fides_pkg.sv - shared parameters, types and FSM encoding for the FIDES inverse MixColumns engine
package fides_pkg;

   localparam int CELL_W  = 6;
   localparam int NROW    = 4;
   localparam int NCOL    = 8;
   localparam int NSHARE  = 3;
   localparam int COL_W   = CELL_W * NROW;
   localparam int STATE_W = COL_W * NCOL;
   localparam int CNT_W   = $clog2(NCOL);

   typedef logic [CELL_W-1:0]  cell_t;
   typedef logic [COL_W-1:0]   col_t;
   typedef logic [STATE_W-1:0] state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_e;

endpackage

// File: rtl/fides_inv_mcol_col.sv
// rtl/fides_inv_mcol_col.sv - combinational involutory column transform (each cell becomes XOR of the other three)
module fides_inv_mcol_col
   import fides_pkg::*;
(
   input  col_t col_i,
   output col_t col_o
);

   cell_t a0, a1, a2, a3, total;

   always_comb begin
      a0    = col_i[0*CELL_W +: CELL_W];
      a1    = col_i[1*CELL_W +: CELL_W];
      a2    = col_i[2*CELL_W +: CELL_W];
      a3    = col_i[3*CELL_W +: CELL_W];
      // XOR of all four, then cancel the cell's own contribution
      total = a0 ^ a1 ^ a2 ^ a3;
      col_o = {total ^ a3, total ^ a2, total ^ a1, total ^ a0};
   end

endmodule

// File: rtl/fides_inv_mcol_serial.sv
// rtl/fides_inv_mcol_serial.sv - 3-share column-serial inverse MixColumns; FIDES_INV_MCOL_UNROLL_EN does all columns in one RUN cycle
module fides_inv_mcol_serial
   import fides_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_s0,
   input  logic [STATE_W-1:0] in_s1,
   input  logic [STATE_W-1:0] in_s2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_s0,
   output logic [STATE_W-1:0] out_s1,
   output logic [STATE_W-1:0] out_s2,
   output logic               busy
);

   fsm_e             fsm_q, fsm_d;
   logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
   state_t           st_q [NSHARE];
   state_t           st_d [NSHARE];
   state_t           in_s [NSHARE];

   assign in_s[0] = in_s0;
   assign in_s[1] = in_s1;
   assign in_s[2] = in_s2;

`ifdef FIDES_INV_MCOL_UNROLL_EN
   state_t full_out [NSHARE];

   for (genvar s = 0; s < NSHARE; s++) begin : g_share
      for (genvar c = 0; c < NCOL; c++) begin : g_col
         fides_inv_mcol_col u_col (
            .col_i (st_q[s][c*COL_W +: COL_W]),
            .col_o (full_out[s][c*COL_W +: COL_W])
         );
      end
   end
`else
   col_t col_in  [NSHARE];
   col_t col_out [NSHARE];

   for (genvar s = 0; s < NSHARE; s++) begin : g_share
      assign col_in[s] = st_q[s][col_cnt_q*COL_W +: COL_W];
      fides_inv_mcol_col u_col (
         .col_i (col_in[s]),
         .col_o (col_out[s])
      );
   end
`endif

   always_comb begin
      fsm_d     = fsm_q;
      col_cnt_d = col_cnt_q;
      for (int s = 0; s < NSHARE; s++) st_d[s] = st_q[s];

      case (fsm_q)
         ST_IDLE: begin
            if (in_valid) begin
               for (int s = 0; s < NSHARE; s++) st_d[s] = in_s[s];
               col_cnt_d = '0;
               fsm_d     = ST_RUN;
            end
         end
         ST_RUN: begin
`ifdef FIDES_INV_MCOL_UNROLL_EN
            for (int s = 0; s < NSHARE; s++) st_d[s] = full_out[s];
            fsm_d = ST_DONE;
`else
            for (int s = 0; s < NSHARE; s++) st_d[s][col_cnt_q*COL_W +: COL_W] = col_out[s];
            // counter is exactly CNT_W wide, so the increment wraps to 0 after the last column
            col_cnt_d = col_cnt_q + 1'b1;
            if (col_cnt_q == CNT_W'(NCOL-1)) fsm_d = ST_DONE;
`endif
         end
         ST_DONE: begin
            if (out_ready) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q     <= ST_IDLE;
         col_cnt_q <= '0;
         for (int s = 0; s < NSHARE; s++) st_q[s] <= '0;
      end else begin
         fsm_q     <= fsm_d;
         col_cnt_q <= col_cnt_d;
         for (int s = 0; s < NSHARE; s++) st_q[s] <= st_d[s];
      end
   end

   assign in_ready  = (fsm_q == ST_IDLE);
   assign out_valid = (fsm_q == ST_DONE);
   assign busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
   assign out_s0    = st_q[0];
   assign out_s1    = st_q[1];
   assign out_s2    = st_q[2];

endmodule
